sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, SRAM address width.
REQ-002 SHALL have parameter WORD_SIZE, default 4, SRAM word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have requester ports p0_/p1_ (p0 = CPU, p1 = loader/debug), x in {0,1}:
- px_req  input  1  access request, held until px_gnt
- px_we  input  1  1 = write, 0 = read
- px_addr  input  ADDR_SIZE  address
- px_wdata  input  WORD_SIZE  write data
- px_gnt  output  1  one-cycle accept pulse; command sampled this cycle
- px_rvalid  output  1  one-cycle read-data-valid pulse
REQ-005 SHALL have rdata  output  WORD_SIZE  read data, shared by both ports, qualified by px_rvalid.
REQ-006 SHALL have clr_req  input  1  start a clear sweep (level, sampled in IDLE); clr_done  output  1  one-cycle pulse at sweep end; busy  output  1  high whenever state != IDLE.
REQ-007 SHALL have SRAM-side ports: sram_a  output  ADDR_SIZE; sram_d  output  WORD_SIZE; sram_wen  output  1  active-low write enable; sram_q  input  WORD_SIZE.

Function
REQ-008 FSM states SHALL be: IDLE, WSETUP, WPULSE, WHOLD, RADDR, RDONE, CSETUP, CPULSE, CHOLD.
REQ-009 In IDLE, priority SHALL be clr_req > port requests; on clr_req the next state is CSETUP with clear address = 0.
REQ-010 In IDLE with no clr_req, px_gnt SHALL be driven combinationally for the arbitration winner only; px_addr, px_wdata and px_we are captured at that edge.
REQ-011 Arbitration SHALL be two-way round-robin: single requester wins; if both request, the port not granted last wins; last-grant register resets to 1 (p0 wins first tie).
REQ-012 Write sequence SHALL be: WSETUP (sram_a/sram_d driven, sram_wen=1) -> WPULSE (sram_wen=0) -> WHOLD (sram_wen=1, a/d unchanged) -> IDLE; 4 cycles gnt-to-next-gnt.
REQ-013 Read sequence SHALL be: RADDR (sram_a driven, sram_wen=1) -> RDONE (rdata = sram_q registered at end of RADDR, px_rvalid=1 for the granted port) -> IDLE; rvalid exactly 2 cycles after gnt.
REQ-014 sram_a, sram_d and sram_wen SHALL be driven from flops only, never glitch, and sram_a/sram_d SHALL NOT change while sram_wen=0.
REQ-015 Clear sweep SHALL write 0 to every address via CSETUP/CPULSE/CHOLD per word, incrementing the address after CHOLD.
REQ-016 At CHOLD of address 2^ADDR_SIZE-1, the sweep SHALL end (no wrap-around write), clr_done SHALL pulse that cycle, and the next state is IDLE; total length 3*2^ADDR_SIZE cycles.
REQ-017 During a sweep no px_gnt SHALL be issued; pending requests remain waiting and are served in IDLE after clr_done.
REQ-018 rdata SHALL hold its last value between reads.
REQ-019 A clock period of at least 10 ns is required, covering the 2 ns SRAM output delay within RADDR.

Reset
REQ-020 On rst_n=0, all of the following SHALL take effect asynchronously: state=IDLE, sram_wen=1, sram_a=0, sram_d=0, rdata=0, clear address=0, last-grant=1; px_gnt, px_rvalid, clr_done and busy SHALL be 0.
REQ-021 Reset during WPULSE/CPULSE SHALL raise sram_wen immediately; the interrupted write is undefined, and the in-flight command is dropped with no rvalid or retry.

Structure
REQ-022 Package sram_ctrl_pkg SHALL hold the FSM state enum and the port-index constants (PORT_CPU=0, PORT_LDR=1).
REQ-023 Round-robin selection SHALL be sub-module rr_arb2 (req[1:0], last-grant in, one-hot grant out, purely combinational); last-grant is updated in sram_ctrl.

Verification
REQ-024 p0 write addr 0x12 data 0x9, then p0 read 0x12 -> p0_gnt at cycle 0, sram_wen low exactly 1 cycle, p0_rvalid 2 cycles after the read gnt with rdata=0x9.
REQ-025 p0 and p1 request reads together, held for 3 accesses -> grants alternate p0,p1,p0; p1_rvalid never pulses for a p0 access.
REQ-026 clr_req with ADDR_SIZE=4 -> 16 write pulses to addresses 0..15 with data 0, clr_done after 48 cycles; p1_req raised mid-sweep is granted only after clr_done; reads of all addresses return 0.
REQ-027 Assertion over all tests -> sram_a/sram_d stable while sram_wen=0, and sram_wen high for at least 1 cycle between any two write pulses.
REQ-028 rst_n low during WPULSE -> sram_wen=1 without a clock edge, all outputs at reset values, FSM in IDLE, and the next request is granted normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM controller: FSM state encoding and requester indices.
package sram_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WSETUP = 4'd1,
    WPULSE = 4'd2,
    WHOLD  = 4'd3,
    RADDR  = 4'd4,
    RDONE  = 4'd5,
    CSETUP = 4'd6,
    CPULSE = 4'd7,
    CHOLD  = 4'd8
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/sram_ctrl_if.sv
// Bundle of requester, clear-control and SRAM-side signals of the SRAM controller.
interface sram_ctrl_if #(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 4
);

  logic                 p0_req;
  logic                 p0_we;
  logic [ADDR_SIZE-1:0] p0_addr;
  logic [WORD_SIZE-1:0] p0_wdata;
  logic                 p0_gnt;
  logic                 p0_rvalid;

  logic                 p1_req;
  logic                 p1_we;
  logic [ADDR_SIZE-1:0] p1_addr;
  logic [WORD_SIZE-1:0] p1_wdata;
  logic                 p1_gnt;
  logic                 p1_rvalid;

  logic [WORD_SIZE-1:0] rdata;
  logic                 clr_req;
  logic                 clr_done;
  logic                 busy;

  logic [ADDR_SIZE-1:0] sram_a;
  logic [WORD_SIZE-1:0] sram_d;
  logic                 sram_wen;
  logic [WORD_SIZE-1:0] sram_q;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  clr_req, sram_q,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    output rdata, clr_done, busy,
    output sram_a, sram_d, sram_wen
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output clr_req, sram_q,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
    input  rdata, clr_done, busy,
    input  sram_a, sram_d, sram_wen
  );

endinterface

// File: rtl/sram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // Grant selection from current requests and last winner
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_i == PORT_LDR) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// Two-port SRAM controller with round-robin arbitration, 3-phase writes,
// 2-cycle reads and a full-array clear sweep. All SRAM pins come straight from flops.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_ctrl_if.slave  bus
);

  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = {ADDR_SIZE{1'b1}};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 port_q, port_d;
  logic [ADDR_SIZE-1:0] sram_a_q, sram_a_d;
  logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
  logic [WORD_SIZE-1:0] sram_d_q, sram_d_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 sram_wen_q, sram_wen_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic                 clr_done_q, clr_done_d;
  logic                 busy_q, busy_d;
  logic [1:0]           req_s, win_s, gnt_s;
  logic                 we_sel_s;

  assign req_s = {bus.p1_req, bus.p0_req};

  rr_arb2 u_arb (
    .req_i  (req_s),
    .last_i (last_q),
    .gnt_o  (win_s)
  );

  // Next-state, capture and pin-value computation
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    sram_a_d   = sram_a_q;
    sram_d_d   = sram_d_q;
    clr_addr_d = clr_addr_q;
    rdata_d    = rdata_q;
    gnt_s      = 2'b00;
    we_sel_s   = win_s[1] ? bus.p1_we : bus.p0_we;

    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d    = CSETUP;
          clr_addr_d = {ADDR_SIZE{1'b0}};
          sram_a_d   = {ADDR_SIZE{1'b0}};
          sram_d_d   = {WORD_SIZE{1'b0}};
        end else if (win_s != 2'b00) begin
          gnt_s    = win_s;
          port_d   = win_s[1] ? PORT_LDR : PORT_CPU;
          last_d   = win_s[1] ? PORT_LDR : PORT_CPU;
          sram_a_d = win_s[1] ? bus.p1_addr : bus.p0_addr;
          sram_d_d = win_s[1] ? bus.p1_wdata : bus.p0_wdata;
          state_d  = we_sel_s ? WSETUP : RADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WSETUP: state_d = WPULSE;
      WPULSE: state_d = WHOLD;
      WHOLD:  state_d = IDLE;
      RADDR: begin
        state_d = RDONE;
        rdata_d = bus.sram_q;
      end
      RDONE:  state_d = IDLE;
      CSETUP: state_d = CPULSE;
      CPULSE: state_d = CHOLD;
      CHOLD: begin
        if (clr_addr_q == ADDR_LAST) begin
          state_d = IDLE;
        end else begin
          state_d    = CSETUP;
          clr_addr_d = clr_addr_q + ADDR_ONE;
          sram_a_d   = clr_addr_q + ADDR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered strobes are decoded from the state being entered so they line up with it
    sram_wen_d = !((state_d == WPULSE) || (state_d == CPULSE));
    rvalid_d   = (state_d == RDONE) ? ((port_d == PORT_LDR) ? 2'b10 : 2'b01) : 2'b00;
    clr_done_d = (state_d == CHOLD) && (clr_addr_d == ADDR_LAST);
    busy_d     = (state_d != IDLE);
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= PORT_LDR;
      port_q     <= PORT_CPU;
      sram_a_q   <= {ADDR_SIZE{1'b0}};
      sram_d_q   <= {WORD_SIZE{1'b0}};
      clr_addr_q <= {ADDR_SIZE{1'b0}};
      rdata_q    <= {WORD_SIZE{1'b0}};
      sram_wen_q <= 1'b1;
      rvalid_q   <= 2'b00;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      sram_a_q   <= sram_a_d;
      sram_d_q   <= sram_d_d;
      clr_addr_q <= clr_addr_d;
      rdata_q    <= rdata_d;
      sram_wen_q <= sram_wen_d;
      rvalid_q   <= rvalid_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.p0_gnt    = gnt_s[0];
  assign bus.p1_gnt    = gnt_s[1];
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.clr_done  = clr_done_q;
  assign bus.busy      = busy_q;
  assign bus.sram_a    = sram_a_q;
  assign bus.sram_d    = sram_d_q;
  assign bus.sram_wen  = sram_wen_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural SRAM and a write-pulse monitor.
module tb_sram_ctrl;

  localparam int AW = 4;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic fill_en;
  int   checks = 0;
  int   failures = 0;
  int   pulses;
  int   done_cyc;

  sram_ctrl_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus ();

  sram_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [2**AW];
  assign bus.sram_q = mem[bus.sram_a];

  // SRAM model: preset to all-ones, then write on any clock edge with sram_wen low
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= 4'hF;
    end else if (!bus.sram_wen) begin
      mem[bus.sram_a] <= bus.sram_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-pulse monitor: a/d stable around each pulse, pulses one cycle wide and separated
  logic          pv = 1'b0;
  logic          pwen;
  logic [AW-1:0] pa;
  logic [WW-1:0] pd;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
    end else begin
      if (pv) begin
        if (!bus.sram_wen) begin
          chk("wen_gap", {31'd0, pwen}, 32'd1);
          chk("a_setup", {28'd0, bus.sram_a}, {28'd0, pa});
          chk("d_setup", {28'd0, bus.sram_d}, {28'd0, pd});
        end
        if (!pwen) begin
          chk("wen_width", {31'd0, bus.sram_wen}, 32'd1);
          chk("a_hold", {28'd0, bus.sram_a}, {28'd0, pa});
          chk("d_hold", {28'd0, bus.sram_d}, {28'd0, pd});
        end
      end
      pv   <= 1'b1;
      pwen <= bus.sram_wen;
      pa   <= bus.sram_a;
      pd   <= bus.sram_d;
    end
  end

  function automatic logic gnt_of(input logic port);
    return port ? bus.p1_gnt : bus.p0_gnt;
  endfunction

  function automatic logic rvalid_of(input logic port);
    return port ? bus.p1_rvalid : bus.p0_rvalid;
  endfunction

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [WW-1:0] d);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end
  endtask

  task automatic wait_gnt(input logic port);
    int n = 0;
    #1;
    while (gnt_of(port) !== 1'b1 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk("gnt_wait", {31'd0, gnt_of(port)}, 32'd1);
  endtask

  task automatic do_write(input logic port, input logic [AW-1:0] a, input logic [WW-1:0] d);
    drive(port, 1'b1, 1'b1, a, d);
    wait_gnt(port);
    @(negedge clk);
    drive(port, 1'b0, 1'b0, a, d);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic port, input logic [AW-1:0] a, input logic [WW-1:0] exp);
    drive(port, 1'b1, 1'b0, a, 4'h0);
    wait_gnt(port);
    @(negedge clk);
    drive(port, 1'b0, 1'b0, a, 4'h0);
    @(negedge clk); #1;
    chk("rd_rvalid", {31'd0, rvalid_of(port)}, 32'd1);
    chk("rd_other_rvalid", {31'd0, rvalid_of(!port)}, 32'd0);
    chk("rd_data", {28'd0, bus.rdata}, {28'd0, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wen"}, {31'd0, bus.sram_wen}, 32'd1);
    chk({tag, "_a"}, {28'd0, bus.sram_a}, 32'd0);
    chk({tag, "_d"}, {28'd0, bus.sram_d}, 32'd0);
    chk({tag, "_rdata"}, {28'd0, bus.rdata}, 32'd0);
    chk({tag, "_gnt"}, {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
    chk({tag, "_clr_done"}, {31'd0, bus.clr_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fill_en = 1'b1;
    bus.clr_req = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_en = 1'b0;

    // p0 write 0x2 <- 0x9, then read it back
    drive(1'b0, 1'b1, 1'b1, 4'h2, 4'h9); #1;
    chk("w_gnt_p0", {31'd0, bus.p0_gnt}, 32'd1);
    chk("w_gnt_p1", {31'd0, bus.p1_gnt}, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 4'h2, 4'h9); #1;
    chk("wsetup_busy", {31'd0, bus.busy}, 32'd1);
    chk("wsetup_wen", {31'd0, bus.sram_wen}, 32'd1);
    chk("wsetup_a", {28'd0, bus.sram_a}, 32'h2);
    chk("wsetup_d", {28'd0, bus.sram_d}, 32'h9);
    @(negedge clk); #1;
    chk("wpulse_wen", {31'd0, bus.sram_wen}, 32'd0);
    @(negedge clk); #1;
    chk("whold_wen", {31'd0, bus.sram_wen}, 32'd1);
    chk("whold_a", {28'd0, bus.sram_a}, 32'h2);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'h2, 4'h0); #1;
    chk("r_gnt_4cyc", {31'd0, bus.p0_gnt}, 32'd1);
    chk("r_idle_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 4'h2, 4'h0); #1;
    chk("raddr_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    @(negedge clk); #1;
    chk("rdone_rvalid_p0", {31'd0, bus.p0_rvalid}, 32'd1);
    chk("rdone_rvalid_p1", {31'd0, bus.p1_rvalid}, 32'd0);
    chk("rdone_rdata", {28'd0, bus.rdata}, 32'h9);
    @(negedge clk); #1;
    chk("after_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
    chk("rdata_hold", {28'd0, bus.rdata}, 32'h9);

    // Round-robin: p1 granted last, so a tie goes p0, p1, p0
    do_write(1'b0, 4'h3, 4'h5);
    do_write(1'b1, 4'h4, 4'h6);
    drive(1'b0, 1'b1, 1'b0, 4'h3, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h4, 4'h0); #1;
    chk("busy_no_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rr_gnt_p0", {31'd0, bus.p0_gnt}, (k == 1) ? 32'd0 : 32'd1);
      chk("rr_gnt_p1", {31'd0, bus.p1_gnt}, (k == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      if (k == 2) begin
        drive(1'b0, 1'b0, 1'b0, 4'h3, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 4'h4, 4'h0);
      end
      @(negedge clk); #1;
      chk("rr_rvalid_p0", {31'd0, bus.p0_rvalid}, (k == 1) ? 32'd0 : 32'd1);
      chk("rr_rvalid_p1", {31'd0, bus.p1_rvalid}, (k == 1) ? 32'd1 : 32'd0);
      chk("rr_rdata", {28'd0, bus.rdata}, (k == 1) ? 32'h6 : 32'h5);
      @(negedge clk);
    end

    // Clear sweep with p1 read waiting throughout
    bus.clr_req = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 4'h4, 4'h0); #1;
    chk("clr_priority", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd0);
    pulses = 0;
    done_cyc = 0;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (c == 1) bus.clr_req = 1'b0;
      #1;
      chk("sweep_no_gnt", {31'd0, bus.p1_gnt}, 32'd0);
      if (!bus.sram_wen) begin
        chk("sweep_addr", {28'd0, bus.sram_a}, pulses);
        chk("sweep_data", {28'd0, bus.sram_d}, 32'd0);
        pulses++;
      end
      if (bus.clr_done && done_cyc == 0) done_cyc = c;
    end
    chk("sweep_pulses", pulses, 32'd16);
    chk("clr_done_cycle", done_cyc, 32'd48);
    chk("sweep_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk); #1;
    chk("post_clr_gnt_p1", {31'd0, bus.p1_gnt}, 32'd1);
    chk("post_clr_done_low", {31'd0, bus.clr_done}, 32'd0);
    chk("post_clr_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 4'h4, 4'h0);
    @(negedge clk); #1;
    chk("post_clr_rvalid", {31'd0, bus.p1_rvalid}, 32'd1);
    chk("post_clr_rdata", {28'd0, bus.rdata}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      do_read(1'b0, 4'(a), 4'h0);
    end

    // Reset in the middle of a write pulse
    do_write(1'b0, 4'h8, 4'hC);
    do_read(1'b1, 4'h8, 4'hC);
    drive(1'b0, 1'b1, 1'b1, 4'h7, 4'h3);
    wait_gnt(1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 4'h7, 4'h3);
    @(negedge clk); #1;
    chk("pre_rst_wpulse", {31'd0, bus.sram_wen}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'h8, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 4'h8, 4'h0); #1;
    chk("rst_tie_p0", {31'd0, bus.p0_gnt}, 32'd1);
    chk("rst_tie_p1", {31'd0, bus.p1_gnt}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h8, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h8, 4'h0);
    @(negedge clk); #1;
    chk("rst_rd_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
    chk("rst_rd_data", {28'd0, bus.rdata}, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
